// File: rtl/tron_ps2_pkg.sv
// rtl/tron_ps2_pkg.sv - shared PS/2 frame constants, command bytes and host transmitter states
package tron_ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_e;

    localparam int         PS2_DATA_BITS = 8;
    localparam logic [3:0] PS2_STOP_EDGE = 4'd10;
    localparam logic [3:0] PS2_ACK_EDGE  = 4'd11;

    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - two-flop synchronizer with registered falling-edge detect per line
module ps2_line_sync #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] prev;

    // Idle PS/2 lines float high, so the chain resets to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta  <= '1;
            level <= '1;
            prev  <= '1;
            fall  <= '0;
        end else begin
            meta  <= pin;
            level <= meta;
            prev  <= level;
            fall  <= prev & ~level;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter with open-drain enables
module ps2_host_tx
    import tron_ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES     = 5000,
    parameter int unsigned RTS_CYCLES         = 100,
    parameter int unsigned FIRST_EDGE_TIMEOUT = 750000,
    parameter int unsigned FRAME_TIMEOUT      = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    ps2_tx_state_e state_q, state_d;

    logic [PS2_DATA_BITS:0] shreg_q, shreg_d;
    logic [3:0]             edge_q, edge_d, edge_inc;
    logic [31:0]            cnt_q, cnt_d;
    logic                   clk_oe_d, dat_oe_d, done_d, error_d;

    logic [1:0] sync_level;
    logic [1:0] sync_fall;
    logic       clk_fall, clk_level, dat_level;
    logic       unused_dat_fall;

    ps2_line_sync #(.WIDTH(2)) u_sync (
        .clk   (clk),
        .reset (reset),
        .pin   ({ps2_dat_in, ps2_clk_in}),
        .level (sync_level),
        .fall  (sync_fall)
    );

    assign clk_fall        = sync_fall[0];
    assign clk_level       = sync_level[0];
    assign dat_level       = sync_level[1];
    assign unused_dat_fall = sync_fall[1];
    assign edge_inc        = edge_q + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            edge_q     <= '0;
            cnt_q      <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            edge_q     <= edge_d;
            cnt_q      <= cnt_d;
            ps2_clk_oe <= clk_oe_d;
            ps2_dat_oe <= dat_oe_d;
            tx_ready   <= (state_d == ST_IDLE);
            busy       <= (state_d != ST_IDLE);
            done       <= done_d;
            error      <= error_d;
        end
    end

    // cnt_q is shared: inhibit length, RTS length, first-edge and frame timeouts.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        edge_d   = edge_q;
        cnt_d    = cnt_q;
        clk_oe_d = ps2_clk_oe;
        dat_oe_d = ps2_dat_oe;
        done_d   = 1'b0;
        error_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_valid && tx_ready) begin
                    shreg_d  = {~^tx_data, tx_data};
                    edge_d   = '0;
                    cnt_d    = INHIBIT_CYCLES - 1;
                    clk_oe_d = 1'b1;
                    state_d  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == 32'd0) begin
                    cnt_d    = RTS_CYCLES - 1;
                    dat_oe_d = 1'b1;
                    state_d  = ST_RTS;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_RTS: begin
                if (cnt_q == 32'd0) begin
                    cnt_d    = FIRST_EDGE_TIMEOUT - 1;
                    clk_oe_d = 1'b0;
                    state_d  = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == 32'd0) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    error_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                    if (clk_fall) begin
                        edge_d = edge_inc;
                        // Frame budget runs from the first device edge to the ACK edge.
                        if (edge_q == 4'd0) begin
                            cnt_d = FRAME_TIMEOUT;
                        end
                        if (edge_inc == PS2_STOP_EDGE) begin
                            dat_oe_d = 1'b0;
                            state_d  = ST_ACK;
                        end else begin
                            dat_oe_d = ~shreg_q[edge_inc - 4'd1];
                        end
                    end
                end
            end
            ST_ACK: begin
                if (cnt_q == 32'd0) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    error_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                    if (clk_fall && edge_inc == PS2_ACK_EDGE) begin
                        edge_d  = edge_inc;
                        done_d  = ~dat_level;
                        error_d = dat_level;
                        state_d = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_level && dat_level) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - randomized self-checking bench with a PS/2 device model for ps2_host_tx
module tb_ps2_host_tx;
    import tron_ps2_pkg::*;

    localparam int I    = 20;
    localparam int R    = 4;
    localparam int FE   = 200;
    localparam int FR   = 400;
    localparam int HALF = 20;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error;
    logic       dev_clk  = 1'b1;
    logic       dev_dat  = 1'b1;
    logic       clk_pin, dat_pin;

    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, acc_cyc = -1;
    int   done_cnt = 0, err_cnt = 0, err_cyc = -1;
    logic err_clk_oe = 1'b0, err_dat_oe = 1'b0;

    assign clk_pin = !ps2_clk_oe && dev_clk;
    assign dat_pin = !ps2_dat_oe && dev_dat;

    ps2_host_tx #(
        .INHIBIT_CYCLES     (I),
        .RTS_CYCLES         (R),
        .FIRST_EDGE_TIMEOUT (FE),
        .FRAME_TIMEOUT      (FR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (clk_pin),
        .ps2_dat_in (dat_pin),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkw(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) (cycle %0d)", name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic logic model_parity(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return logic'(ones % 2 == 0);
    endfunction

    // Every-cycle checker: reset values, pulse exclusivity, and the inhibit/RTS timeline after accept.
    always @(negedge clk) begin
        if (reset) begin
            acc_cyc = -1;
            chk1("rst_clk_oe", ps2_clk_oe, 1'b0);
            chk1("rst_dat_oe", ps2_dat_oe, 1'b0);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_done", done, 1'b0);
            chk1("rst_error", error, 1'b0);
            chk1("rst_ready", tx_ready, 1'b0);
        end else begin
            if (done) done_cnt++;
            if (error) begin
                err_cnt++;
                err_cyc    = cyc;
                err_clk_oe = ps2_clk_oe;
                err_dat_oe = ps2_dat_oe;
            end
            chk1("done_error_excl", done && error, 1'b0);
            chk1("ready_vs_busy", tx_ready, !busy);
            if (acc_cyc >= 0 && cyc >= acc_cyc && cyc <= acc_cyc + I + R) begin
                chk1("win_busy", busy, 1'b1);
                chk1("win_clk_oe", ps2_clk_oe, cyc < acc_cyc + I + R);
                chk1("win_dat_oe", ps2_dat_oe, cyc >= acc_cyc + I);
            end
            if (tx_valid && tx_ready) acc_cyc = cyc + 1;
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1 tx_data = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    // Device: waits for request-to-send, clocks n_edges at a 40-cycle period, samples on rising clock.
    task automatic device_frame(input bit ack, input int n_edges, input int delay,
                                output logic [9:0] bits, output bit ok);
        int t = 0;
        bits = '0;
        while (!(clk_pin && !dat_pin) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        ok = (t < 1000);
        if (!ok) return;
        repeat (delay) @(negedge clk);
        for (int k = 1; k <= n_edges; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (k == n_edges && n_edges < 11) return;
            dev_clk = 1'b1;
            if (k <= 10) bits[k-1] = dat_pin;
            if (k == 10 && ack) begin
                repeat (HALF / 2) @(negedge clk);
                dev_dat = 1'b0;
                repeat (HALF / 2) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        dev_dat = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk1({name, "_idle"}, busy, 1'b0);
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack, input string name,
                             output logic [9:0] bits);
        int d0 = done_cnt;
        int e0 = err_cnt;
        bit ok;
        send(b);
        device_frame(ack, 11, int'($urandom_range(0, 60)), bits, ok);
        chk1({name, "_start"}, ok, 1'b1);
        wait_idle(name);
        @(negedge clk);
        chkw({name, "_data"}, int'(bits[7:0]), int'(b));
        chk1({name, "_parity"}, bits[8], model_parity(b));
        chk1({name, "_stop"}, bits[9], 1'b1);
        chkw({name, "_done"}, done_cnt - d0, ack ? 1 : 0);
        chkw({name, "_error"}, err_cnt - e0, ack ? 0 : 1);
    endtask

    initial begin
        logic [9:0] bits;
        logic [7:0] b;
        logic [7:0] sweep [4];
        logic       sweep_par [4];
        int         d0, e0, t;
        bit         ok;

        sweep     = '{8'h00, 8'hFF, 8'h01, 8'h80};
        sweep_par = '{1'b1, 1'b1, 1'b0, 1'b0};

        repeat (4) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk1("ready_after_reset", tx_ready, 1'b1);
        chk1("busy_after_reset", busy, 1'b0);

        run_frame(PS2_CMD_SET_LED, 1'b1, "led", bits);
        chkw("led_literal", int'(bits), 32'h3ED);

        for (int i = 0; i < 4; i++) begin
            run_frame(sweep[i], 1'b1, "sweep", bits);
            chk1("sweep_literal_parity", bits[8], sweep_par[i]);
        end

        run_frame(PS2_CMD_RESET, 1'b0, "noack", bits);
        chk1("noack_ready", tx_ready, 1'b1);

        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hA5);
        t = 0;
        while (err_cnt == e0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chkw("silent_err_cycle", err_cyc, acc_cyc + I + R + FE);
        chk1("silent_clk_oe", err_clk_oe, 1'b0);
        chk1("silent_dat_oe", err_dat_oe, 1'b0);
        while (cyc < err_cyc + 1) @(negedge clk);
        chk1("silent_ready", tx_ready, 1'b1);
        chkw("silent_done", done_cnt - d0, 0);

        b = 8'($urandom);
        fork
            run_frame(b, 1'b1, "busyreq", bits);
            begin
                repeat (150) @(negedge clk);
                send(PS2_CMD_ENABLE);
            end
        join
        repeat (40) @(negedge clk);
        chk1("busyreq_not_queued", busy, 1'b0);
        run_frame(PS2_CMD_ENABLE, 1'b1, "enable", bits);

        d0 = done_cnt;
        e0 = err_cnt;
        b  = 8'h25;
        send(b);
        device_frame(1'b1, 5, 10, bits, ok);
        chk1("rstmid_started", ok, 1'b1);
        chk1("rstmid_pre_dat_oe", ps2_dat_oe, ~b[4]);
        #1 reset = 1'b1;
        #1;
        chk1("rstmid_clk_oe", ps2_clk_oe, 1'b0);
        chk1("rstmid_dat_oe", ps2_dat_oe, 1'b0);
        chk1("rstmid_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        #1 reset = 1'b0;
        chkw("rstmid_done", done_cnt - d0, 0);
        chkw("rstmid_error", err_cnt - e0, 0);
        run_frame(8'($urandom), 1'b1, "after_rst", bits);

        for (int i = 0; i < 6; i++) begin
            run_frame(8'($urandom), $urandom_range(0, 4) != 0, "rand", bits);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
